// File: rtl/bypass_merge_n.sv
// Round-robin merge of NUM_IN metadata+packet streams onto one output; channel 0 is the bypass path.
// Grant-to-valid 1 cycle, data paths 0 cycles; only the granted channel sees ready, no new grant while out_almost_full.
module bypass_merge_n #(
  parameter int NUM_IN  = 2,
  parameter int DATA_W  = 512,
  parameter int META_W  = 128,
  parameter int EMPTY_W = 6,
  parameter int CH_W    = $clog2(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*META_W-1:0]    in_meta_data,
  input  logic [NUM_IN-1:0]           in_meta_valid,
  output logic [NUM_IN-1:0]           in_meta_ready,
  input  logic [NUM_IN*DATA_W-1:0]    in_pkt_data,
  input  logic [NUM_IN-1:0]           in_pkt_sop,
  input  logic [NUM_IN-1:0]           in_pkt_eop,
  input  logic [NUM_IN*EMPTY_W-1:0]   in_pkt_empty,
  input  logic [NUM_IN-1:0]           in_pkt_valid,
  output logic [NUM_IN-1:0]           in_pkt_ready,
  output logic [META_W-1:0]           out_meta_data,
  output logic                        out_meta_valid,
  input  logic                        out_meta_ready,
  output logic [DATA_W-1:0]           out_pkt_data,
  output logic                        out_pkt_sop,
  output logic                        out_pkt_eop,
  output logic [EMPTY_W-1:0]          out_pkt_empty,
  output logic                        out_pkt_valid,
  input  logic                        out_pkt_ready,
  input  logic                        out_almost_full,
  output logic [CH_W-1:0]             out_channel,
  output logic [NUM_IN*32-1:0]        pkt_cnt,
  output logic                        proto_err
);
  typedef enum logic [1:0] {IDLE, META, PKT} state_t;

  state_t               state;
  logic [CH_W-1:0]      grant;
  logic [CH_W-1:0]      last_grant;
  logic                 first_beat;
  logic [NUM_IN*32-1:0] cnt_q;

  logic [META_W-1:0]    meta_arr  [NUM_IN];
  logic [DATA_W-1:0]    data_arr  [NUM_IN];
  logic [EMPTY_W-1:0]   empty_arr [NUM_IN];

  logic                 rr_found;
  logic [CH_W-1:0]      rr_sel;
  logic [CH_W-1:0]      rr_idx;
  logic                 meta_acc;
  logic                 pkt_acc;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign meta_arr[i]  = in_meta_data[i*META_W +: META_W];
    assign data_arr[i]  = in_pkt_data[i*DATA_W +: DATA_W];
    assign empty_arr[i] = in_pkt_empty[i*EMPTY_W +: EMPTY_W];
  end

  // Data paths are pure muxes on the registered grant; only the valids are state-qualified.
  assign out_meta_data  = meta_arr[grant];
  assign out_meta_valid = (state == META) && in_meta_valid[grant];
  assign out_pkt_data   = data_arr[grant];
  assign out_pkt_sop    = in_pkt_sop[grant];
  assign out_pkt_eop    = in_pkt_eop[grant];
  assign out_pkt_empty  = empty_arr[grant];
  assign out_pkt_valid  = (state == PKT) && in_pkt_valid[grant];
  assign out_channel    = grant;
  assign pkt_cnt        = cnt_q;
  assign meta_acc       = out_meta_valid && out_meta_ready;
  assign pkt_acc        = out_pkt_valid && out_pkt_ready;

  always_comb begin
    in_meta_ready = '0;
    in_pkt_ready  = '0;
    if (state == META) in_meta_ready[grant] = out_meta_ready;
    if (state == PKT)  in_pkt_ready[grant]  = out_pkt_ready;
  end

  // Search starts one past the previous winner so every requester is served within NUM_IN grants.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_idx = CH_W'((int'(last_grant) + k) % NUM_IN);
      if (!rr_found && in_meta_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_IN - 1);
      first_beat <= 1'b0;
      cnt_q      <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_found && !out_almost_full) begin
            grant      <= rr_sel;
            last_grant <= rr_sel;
            state      <= META;
          end
        end
        META: begin
          if (meta_acc) begin
            state      <= PKT;
            first_beat <= 1'b1;
          end
        end
        PKT: begin
          if (pkt_acc) begin
            first_beat <= 1'b0;
            // sop must be set on exactly the first accepted beat of a packet
            if (first_beat != out_pkt_sop) proto_err <= 1'b1;
            if (out_pkt_eop) begin
              state <= IDLE;
              for (int i = 0; i < NUM_IN; i++) begin
                if (grant == CH_W'(i)) cnt_q[i*32 +: 32] <= cnt_q[i*32 +: 32] + 32'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_merge_n.sv
// Randomized scoreboard bench for bypass_merge_n with a queue-based round-robin reference model.
module tb_bypass_merge_n;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MW = 32;
  localparam int EW = 6;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*MW-1:0]   in_meta_data;
  logic [N-1:0]      in_meta_valid;
  logic [N-1:0]      in_meta_ready;
  logic [N*DW-1:0]   in_pkt_data;
  logic [N-1:0]      in_pkt_sop;
  logic [N-1:0]      in_pkt_eop;
  logic [N*EW-1:0]   in_pkt_empty;
  logic [N-1:0]      in_pkt_valid;
  logic [N-1:0]      in_pkt_ready;
  logic [MW-1:0]     out_meta_data;
  logic              out_meta_valid;
  logic              out_meta_ready;
  logic [DW-1:0]     out_pkt_data;
  logic              out_pkt_sop;
  logic              out_pkt_eop;
  logic [EW-1:0]     out_pkt_empty;
  logic              out_pkt_valid;
  logic              out_pkt_ready;
  logic              out_almost_full;
  logic [CW-1:0]     out_channel;
  logic [N*32-1:0]   pkt_cnt;
  logic              proto_err;

  bypass_merge_n #(.NUM_IN(N), .DATA_W(DW), .META_W(MW), .EMPTY_W(EW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .in_pkt_data(in_pkt_data), .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_almost_full(out_almost_full), .out_channel(out_channel),
    .pkt_cnt(pkt_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;
  typedef struct packed {
    logic [CW-1:0] ch;
    logic [MW-1:0] meta;
  } exp_meta_t;
  typedef struct packed {
    logic [CW-1:0] ch;
    beat_t         b;
  } exp_beat_t;

  logic [MW-1:0] src_meta [N][$];
  beat_t         src_beat [N][$];
  logic [MW-1:0] stg_meta [N][$];
  int            stg_len  [N][$];
  beat_t         stg_beat [N][$];
  exp_meta_t     exp_meta [$];
  exp_beat_t     exp_beat [$];

  int          rr_ptr;
  logic [31:0] m_cnt [N];
  logic        m_err;
  int          checks = 0;
  int          errors = 0;
  bit          rand_mode = 1'b0;
  bit          af_dir = 1'b0;
  logic [N*32-1:0] preload;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output beat seen with nothing expected", name);
  endtask

  task automatic model_reset();
    rr_ptr = N - 1;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 32'd0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      src_meta[i].delete(); src_beat[i].delete();
      stg_meta[i].delete(); stg_len[i].delete(); stg_beat[i].delete();
    end
    exp_meta.delete();
    exp_beat.delete();
  endtask

  task automatic gen_pkt(input int ch, input int len, input bit bad);
    beat_t b;
    stg_meta[ch].push_back($urandom);
    stg_len[ch].push_back(len);
    for (int k = 0; k < len; k++) begin
      b.data  = {$urandom, $urandom};
      b.sop   = (k == 0) || (bad && k == 1);
      b.eop   = (k == len - 1);
      b.empty = (k == len - 1) ? EW'($urandom_range(0, 63)) : '0;
      stg_beat[ch].push_back(b);
    end
    if (bad) m_err = 1'b1;
  endtask

  // Reference order: rotate a pointer, serve the next channel that still has staged packets.
  task automatic commit();
    int rem [N];
    int total, c, len;
    exp_meta_t em;
    exp_beat_t eb;
    logic [MW-1:0] m;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = stg_len[i].size();
      total += rem[i];
    end
    for (int g = 0; g < total; g++) begin
      c = -1;
      for (int k = 1; k <= N; k++)
        if (c < 0 && rem[(rr_ptr + k) % N] > 0) c = (rr_ptr + k) % N;
      rr_ptr = c;
      rem[c]--;
      m = stg_meta[c].pop_front();
      src_meta[c].push_back(m);
      em.ch = CW'(c); em.meta = m;
      exp_meta.push_back(em);
      len = stg_len[c].pop_front();
      for (int k = 0; k < len; k++) begin
        eb.ch = CW'(c);
        eb.b  = stg_beat[c].pop_front();
        src_beat[c].push_back(eb.b);
        exp_beat.push_back(eb);
      end
      m_cnt[c] = m_cnt[c] + 32'd1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_meta.size() != 0 || exp_beat.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_meta.size() + exp_beat.size()), 64'd0);
    if (exp_meta.size() != 0 || exp_beat.size() != 0) clear_queues();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_pkt_cnt%0d", tag, i), 64'(pkt_cnt[i*32 +: 32]), 64'(m_cnt[i]));
    chk($sformatf("%s_proto_err", tag), 64'(proto_err), 64'(m_err));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_meta_valid"}, 64'(out_meta_valid), 64'd0);
    chk({tag, "_pkt_valid"},  64'(out_pkt_valid),  64'd0);
    chk({tag, "_meta_ready"}, 64'(in_meta_ready),  64'd0);
    chk({tag, "_pkt_ready"},  64'(in_pkt_ready),   64'd0);
    chk({tag, "_channel"},    64'(out_channel),    64'd0);
    chk({tag, "_pkt_cnt"},    64'(pkt_cnt),        64'd0);
    chk({tag, "_proto_err"},  64'(proto_err),      64'd0);
  endtask

  // Source driver: handshakes are sampled mid-cycle, queues advance just after the edge.
  initial begin
    bit macc [N];
    bit pacc [N];
    beat_t b;
    in_meta_data = '0; in_meta_valid = '0; in_pkt_data = '0; in_pkt_sop = '0;
    in_pkt_eop = '0; in_pkt_empty = '0; in_pkt_valid = '0;
    out_meta_ready = 1'b1; out_pkt_ready = 1'b1; out_almost_full = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        macc[i] = in_meta_valid[i] && in_meta_ready[i];
        pacc[i] = in_pkt_valid[i] && in_pkt_ready[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (macc[i] && src_meta[i].size() != 0) void'(src_meta[i].pop_front());
        if (pacc[i] && src_beat[i].size() != 0) void'(src_beat[i].pop_front());
        in_meta_valid[i] = (src_meta[i].size() != 0);
        in_meta_data[i*MW +: MW] = (src_meta[i].size() != 0) ? src_meta[i][0] : '0;
        b = (src_beat[i].size() != 0) ? src_beat[i][0] : '0;
        in_pkt_valid[i] = (src_beat[i].size() != 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        in_pkt_data[i*DW +: DW]  = b.data;
        in_pkt_sop[i]            = b.sop;
        in_pkt_eop[i]            = b.eop;
        in_pkt_empty[i*EW +: EW] = b.empty;
      end
      out_meta_ready  = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_pkt_ready   = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_almost_full = rand_mode ? ($urandom_range(0, 4) == 0) : af_dir;
    end
  end

  // Monitor: pop and compare on every output handshake.
  initial begin
    exp_meta_t em;
    exp_beat_t eb;
    forever begin
      @(negedge clk);
      if (!rst && out_meta_valid && out_meta_ready) begin
        if (exp_meta.size() == 0) fail_evt("meta_unexpected");
        else begin
          em = exp_meta.pop_front();
          chk("meta_data",    64'(out_meta_data), 64'(em.meta));
          chk("meta_channel", 64'(out_channel),   64'(em.ch));
        end
      end
      if (!rst && out_pkt_valid && out_pkt_ready) begin
        if (exp_beat.size() == 0) fail_evt("beat_unexpected");
        else begin
          eb = exp_beat.pop_front();
          chk("beat_data",    out_pkt_data,         eb.b.data);
          chk("beat_sop",     64'(out_pkt_sop),     64'(eb.b.sop));
          chk("beat_eop",     64'(out_pkt_eop),     64'(eb.b.eop));
          chk("beat_empty",   64'(out_pkt_empty),   64'(eb.b.empty));
          chk("beat_channel", 64'(out_channel),     64'(eb.ch));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Four single-beat packets plus one more on ch0: order 0,1,2,3,0.
    gen_pkt(0, 1, 0); gen_pkt(0, 1, 0);
    gen_pkt(1, 1, 0); gen_pkt(2, 1, 0); gen_pkt(3, 1, 0);
    commit();
    drain("rr_drain", 200);
    check_model("rr");

    // Three-beat ch1 packet competes with pending ch0 metadata.
    gen_pkt(1, 3, 0); gen_pkt(0, 1, 0);
    commit();
    drain("contig_drain", 200);
    check_model("contig");

    // Almost-full raised during beat 2 of a 4-beat ch2 packet; ch3 must wait.
    gen_pkt(2, 4, 0); gen_pkt(3, 1, 0);
    commit();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(out_pkt_valid && out_pkt_ready && out_pkt_sop && out_channel == 2) && n < 200);
    chk("af_start_seen", 64'(n < 200), 64'd1);
    af_dir = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(out_pkt_valid && out_pkt_ready && out_pkt_eop && out_channel == 2) && n < 200);
    chk("af_eop_seen", 64'(n < 200), 64'd1);
    repeat (8) begin
      @(negedge clk);
      chk("af_no_grant", 64'(out_meta_valid || out_pkt_valid), 64'd0);
    end
    af_dir = 1'b0;
    drain("af_drain", 200);
    check_model("af");

    // Randomized traffic with backpressure, bubbles and almost-full.
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) gen_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), 0);
    commit();
    drain("rand_drain", 5000);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_model("rand");

    // Second beat carries sop: sticky error, still counted, later traffic still forwarded.
    gen_pkt(0, 3, 1);
    commit();
    drain("err_drain", 200);
    check_model("err");
    gen_pkt(1, 2, 0);
    commit();
    drain("err_post_drain", 200);
    check_model("err_post");

    // Counter wrap from all-ones.
    preload = {m_cnt[3], m_cnt[2], m_cnt[1], 32'hFFFF_FFFF};
    force dut.cnt_q = preload;
    @(negedge clk);
    release dut.cnt_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    chk("wrap_preload", 64'(pkt_cnt[31:0]), 64'h0000_0000_FFFF_FFFF);
    gen_pkt(0, 2, 0);
    commit();
    drain("wrap_drain", 200);
    check_model("wrap");

    // Reset asserted mid-packet.
    gen_pkt(1, 6, 0);
    commit();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(out_pkt_valid && out_channel == 1) && n < 200);
    chk("midpkt_seen", 64'(n < 200), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_quiet("async_rst");
    clear_queues();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    gen_pkt(1, 2, 0); gen_pkt(0, 1, 0);
    commit();
    drain("post_rst_drain", 200);
    check_model("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bypass_merge_n.md
BYPASS_MERGE_N -- requirements
Module: bypass_merge_n

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_IN, 2, number of input channels (legal 2..8); channel 0 is the bypass path.
- DATA_W, 512, packet data width.
- META_W, 128, metadata width.
- EMPTY_W, 6, empty-byte-count width.
- CH_W, $clog2(NUM_IN), channel index width.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_meta_data  in  NUM_IN*META_W  flattened, channel i at [i*META_W +: META_W].
- in_meta_valid  in  NUM_IN  per-channel metadata valid.
- in_meta_ready  out  NUM_IN  per-channel metadata ready.
- in_pkt_data  in  NUM_IN*DATA_W  flattened packet data.
- in_pkt_sop  in  NUM_IN  start of packet.
- in_pkt_eop  in  NUM_IN  end of packet.
- in_pkt_empty  in  NUM_IN*EMPTY_W  empty byte count.
- in_pkt_valid  in  NUM_IN  packet beat valid.
- in_pkt_ready  out  NUM_IN  packet beat ready.
- out_meta_data  out  META_W  merged metadata.
- out_meta_valid  out  1  metadata valid.
- out_meta_ready  in  1  metadata ready.
- out_pkt_data  out  DATA_W  merged packet data.
- out_pkt_sop  out  1  start of packet.
- out_pkt_eop  out  1  end of packet.
- out_pkt_empty  out  EMPTY_W  empty byte count.
- out_pkt_valid  out  1  packet beat valid.
- out_pkt_ready  in  1  packet beat ready.
- out_almost_full  in  1  downstream almost full.
- out_channel  out  CH_W  currently granted channel.
- pkt_cnt  out  NUM_IN*32  per-channel count of completed packets.
- proto_err  out  1  sticky framing error.

Function
REQ-003 The FSM SHALL have three states: IDLE, META, PKT.
REQ-004 In IDLE with any in_meta_valid set and out_almost_full=0, the block SHALL grant by round robin, searching from last_grant+1 modulo NUM_IN, register the grant, update last_grant and move to META.
REQ-005 In IDLE with out_almost_full=1, the block SHALL issue no grant; a packet already granted SHALL always complete regardless of out_almost_full.
REQ-006 In META, out_meta_* SHALL combinationally mirror the granted channel's meta, and in_meta_ready[g] SHALL equal out_meta_ready; a handshake SHALL move the FSM to PKT.
REQ-007 In PKT, out_pkt_* SHALL combinationally mirror the granted channel's packet signals, and in_pkt_ready[g] SHALL equal out_pkt_ready; a beat with valid&ready&eop SHALL return the FSM to IDLE and increment pkt_cnt[g].
REQ-008 Ungranted channels SHALL see ready=0, and in states other than META/PKT the corresponding out_*_valid SHALL be 0.
REQ-009 Latency: grant to first output valid is 1 cycle, data paths are 0 cycles, and the minimum packet spacing is 2 cycles (IDLE, then META).
REQ-010 pkt_cnt entries SHALL be 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-011 proto_err SHALL set, and stay set until reset, when either condition occurs:
- the first accepted beat in PKT has sop=0;
- a later accepted beat of the same packet has sop=1.
Forwarding SHALL continue unchanged after an error.
REQ-012 A single-beat packet (sop=eop=1) SHALL be legal.
REQ-013 Metadata and packet of one grant SHALL never interleave with another channel.
REQ-014 out_channel SHALL hold the granted index from META through PKT and hold its last value in IDLE.

Reset
REQ-015 rst=1 SHALL asynchronously force the following, with all output valids and in_*_ready low:
- state = IDLE;
- last_grant = NUM_IN-1, so channel 0 wins first;
- out_channel = 0;
- pkt_cnt = 0;
- proto_err = 0.
REQ-016 Reset asserted mid-packet SHALL abandon the packet; after release the next grant SHALL start from channel 0.

Verification
REQ-017 NUM_IN=4, all channels hold 1-beat packets, ready=1 -> grant order 0,1,2,3,0 and each pkt_cnt=1 after 4 packets.
REQ-018 ch1 sends a 3-beat packet while ch0 meta is valid -> 3 contiguous ch1 beats, then ch0 granted; out_channel=1 throughout ch1's beats.
REQ-019 out_almost_full=1 during ch2 beat 2 of 4 -> remaining beats are forwarded, then no new grant until out_almost_full=0.
REQ-020 Beat 2 carries sop=1 -> proto_err=1 and remains 1; pkt_cnt still increments at eop.
REQ-021 pkt_cnt[0] preloaded via force to 0xFFFFFFFF, one packet sent -> pkt_cnt[0]=0.
REQ-022 rst pulsed during the PKT state -> all readies and valids are 0 asynchronously, and the first post-reset grant goes to channel 0.
